// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types for the multicycle RV32I control FSM: states, datapath mux selects and opcodes.
package multicycle_control_fsm_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_LUI      = 4'd8,
        S_AUIPC    = 4'd9,
        S_ALUWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
        S_JALR     = 4'd13,
        S_LINKWB   = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        A_PC    = 2'd0,
        A_OLDPC = 2'd1,
        A_RS1   = 2'd2,
        A_ZERO  = 2'd3
    } alu_src_a_t;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_MEM    = 2'd1,
        RES_ALU    = 2'd2
    } result_src_t;

    typedef enum logic [6:0] {
        OP_ITYPE_LOAD  = 7'b0000011,
        OP_FENCE       = 7'b0001111,
        OP_ITYPE_LOGIC = 7'b0010011,
        OP_UTYPE_AUIPC = 7'b0010111,
        OP_STYPE       = 7'b0100011,
        OP_RTYPE       = 7'b0110011,
        OP_UTYPE_LUI   = 7'b0110111,
        OP_BTYPE       = 7'b1100011,
        OP_ITYPE_JALR  = 7'b1100111,
        OP_JTYPE       = 7'b1101111
    } opcode_t;

endpackage

// File: rtl/multicycle_control_fsm_branch_condition.sv
// Branch resolution: maps funct3 and the ALU compare flags to a taken decision.
module branch_condition (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: state register, dispatch logic,
// Moore-style datapath selects and the sticky illegal-instruction flag.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         alu_zero,
    input  logic         alu_lt,
    input  logic         alu_ltu,
    input  logic         mem_ready,
    output logic         mem_req,
    output logic         mem_write,
    output logic         adr_src,
    output logic         ir_write,
    output logic         pc_write,
    output logic         reg_write,
    output logic [1:0]   alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   result_src,
    output logic [STATE_W-1:0] state,
    output logic         illegal_instr
);

    state_t      state_reg, state_next;
    logic        illegal_reg;
    logic        branch_taken;
    alu_src_a_t  src_a;
    alu_src_b_t  src_b;
    result_src_t res_sel;

    branch_condition u_branch_condition (
        .funct3 (funct3),
        .zero   (alu_zero),
        .lt     (alu_lt),
        .ltu    (alu_ltu),
        .taken  (branch_taken)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next == S_TRAP) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ITYPE_LOAD, OP_STYPE: state_next = S_MEMADR;
                    OP_RTYPE:                state_next = S_EXECUTER;
                    OP_ITYPE_LOGIC:          state_next = S_EXECUTEI;
                    OP_BTYPE:                state_next = S_BRANCH;
                    OP_JTYPE:                state_next = S_JAL;
                    OP_ITYPE_JALR:           state_next = S_JALR;
                    OP_UTYPE_LUI:            state_next = S_LUI;
                    OP_UTYPE_AUIPC:          state_next = S_AUIPC;
                    OP_FENCE:                state_next = S_FETCH;
                    default:                 state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_ITYPE_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH, S_LINKWB: state_next = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC: state_next = S_ALUWB;
            S_JAL, S_JALR: state_next = S_LINKWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Every select and enable is forced to zero while reset is held low.
    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        adr_src   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        src_a     = A_PC;
        src_b     = B_RS2;
        res_sel   = RES_ALUOUT;
        if (reset) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    src_b    = B_FOUR;
                    res_sel  = RES_ALU;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    src_a = A_OLDPC;
                    src_b = B_IMM;
                end
                S_MEMADR, S_EXECUTEI: begin
                    src_a = A_RS1;
                    src_b = B_IMM;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    res_sel   = RES_MEM;
                    reg_write = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECUTER: src_a = A_RS1;
                S_LUI: begin
                    src_a = A_ZERO;
                    src_b = B_IMM;
                end
                S_AUIPC: begin
                    src_a = A_OLDPC;
                    src_b = B_IMM;
                end
                S_ALUWB:  reg_write = 1'b1;
                S_BRANCH: begin
                    src_a    = A_RS1;
                    pc_write = branch_taken;
                end
                S_JAL:    pc_write = 1'b1;
                S_JALR: begin
                    src_a    = A_RS1;
                    src_b    = B_IMM;
                    res_sel  = RES_ALU;
                    pc_write = 1'b1;
                end
                S_LINKWB: begin
                    src_a     = A_OLDPC;
                    src_b     = B_FOUR;
                    res_sel   = RES_ALU;
                    reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign alu_src_a     = src_a;
    assign alu_src_b     = src_b;
    assign result_src    = res_sel;
    assign state         = state_reg;
    assign illegal_instr = illegal_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: builds the expected per-cycle trace of
// each instruction from its class, compares it every cycle, and pins cycle counts.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lt, alu_ltu, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] state;
    logic       illegal_instr;

    int tests = 0;
    int fails = 0;
    bit exp_illegal = 1'b0;

    // en = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
    typedef struct packed {
        logic [3:0] st;
        logic       chk_st;
        logic [5:0] en;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] r;
        logic       ill;
        logic       chk_ill;
    } exp_t;

    exp_t exp_q[$];

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .state(state),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] act_en;
            bit ok;
            e = exp_q.pop_front();
            act_en = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write};
            ok = (act_en === e.en) && (alu_src_a === e.a) && (alu_src_b === e.b) &&
                 (result_src === e.r) && (!e.chk_st || state === e.st) &&
                 (!e.chk_ill || illegal_instr === e.ill);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL cycle t=%0t: got st=%0d en=%b a=%0d b=%0d r=%0d ill=%b, want st=%0d en=%b a=%0d b=%0d r=%0d ill=%b",
                         $time, state, act_en, alu_src_a, alu_src_b, result_src, illegal_instr,
                         e.st, e.en, e.a, e.b, e.r, e.ill);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic bit br_taken(input logic [2:0] f3, input bit z, input bit lt, input bit ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        case (op)
            OP_ITYPE_LOAD, OP_FENCE, OP_ITYPE_LOGIC, OP_UTYPE_AUIPC, OP_STYPE,
            OP_RTYPE, OP_UTYPE_LUI, OP_BTYPE, OP_ITYPE_JALR, OP_JTYPE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: drive mem_ready, record what the outputs must be, advance.
    task automatic cyc(input state_t st, input logic mr, input logic [5:0] en,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] r);
        exp_t e;
        mem_ready = mr;
        e.st = st; e.chk_st = 1'b1; e.en = en; e.a = a; e.b = b; e.r = r;
        e.ill = exp_illegal; e.chk_ill = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            e.st = S_FETCH; e.chk_st = (i > 0); e.en = 6'b0; e.a = 2'd0; e.b = 2'd0;
            e.r = 2'd0; e.ill = 1'b0; e.chk_ill = (i > 0);
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_illegal = 1'b0;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one instruction; returns cycles spent from first FETCH cycle to return to FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit z,
                             input bit lt, input bit ltu, input int fw, input int mw,
                             input int trap_hold, output int cycles);
        opcode = op; funct3 = f3; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        cycles = 0;
        for (int i = 0; i < fw; i++) begin
            cyc(S_FETCH, 1'b0, 6'b100000, 2'd0, 2'd2, 2'd2); cycles++;
        end
        cyc(S_FETCH, 1'b1, 6'b100110, 2'd0, 2'd2, 2'd2); cycles++;
        cyc(S_DECODE, rnd(), 6'b0, 2'd1, 2'd1, 2'd0); cycles++;
        case (op)
            OP_ITYPE_LOAD: begin
                cyc(S_MEMADR, rnd(), 6'b0, 2'd2, 2'd1, 2'd0); cycles++;
                for (int i = 0; i < mw; i++) begin
                    cyc(S_MEMREAD, 1'b0, 6'b101000, 2'd0, 2'd0, 2'd0); cycles++;
                end
                cyc(S_MEMREAD, 1'b1, 6'b101000, 2'd0, 2'd0, 2'd0); cycles++;
                cyc(S_MEMWB, rnd(), 6'b000001, 2'd0, 2'd0, 2'd1); cycles++;
            end
            OP_STYPE: begin
                cyc(S_MEMADR, rnd(), 6'b0, 2'd2, 2'd1, 2'd0); cycles++;
                for (int i = 0; i < mw; i++) begin
                    cyc(S_MEMWRITE, 1'b0, 6'b111000, 2'd0, 2'd0, 2'd0); cycles++;
                end
                cyc(S_MEMWRITE, 1'b1, 6'b111000, 2'd0, 2'd0, 2'd0); cycles++;
            end
            OP_RTYPE, OP_ITYPE_LOGIC, OP_UTYPE_LUI, OP_UTYPE_AUIPC: begin
                if (op == OP_RTYPE)           cyc(S_EXECUTER, rnd(), 6'b0, 2'd2, 2'd0, 2'd0);
                else if (op == OP_ITYPE_LOGIC) cyc(S_EXECUTEI, rnd(), 6'b0, 2'd2, 2'd1, 2'd0);
                else if (op == OP_UTYPE_LUI)   cyc(S_LUI, rnd(), 6'b0, 2'd3, 2'd1, 2'd0);
                else                           cyc(S_AUIPC, rnd(), 6'b0, 2'd1, 2'd1, 2'd0);
                cycles++;
                cyc(S_ALUWB, rnd(), 6'b000001, 2'd0, 2'd0, 2'd0); cycles++;
            end
            OP_BTYPE: begin
                cyc(S_BRANCH, rnd(), {4'b0, br_taken(f3, z, lt, ltu), 1'b0}, 2'd2, 2'd0, 2'd0);
                cycles++;
            end
            OP_JTYPE, OP_ITYPE_JALR: begin
                if (op == OP_JTYPE) cyc(S_JAL, rnd(), 6'b000010, 2'd0, 2'd0, 2'd0);
                else                cyc(S_JALR, rnd(), 6'b000010, 2'd2, 2'd1, 2'd2);
                cycles++;
                cyc(S_LINKWB, rnd(), 6'b000001, 2'd1, 2'd2, 2'd2); cycles++;
            end
            OP_FENCE: ;
            default: begin
                exp_illegal = 1'b1;
                for (int i = 0; i < trap_hold; i++) cyc(S_TRAP, rnd(), 6'b0, 2'd0, 2'd0, 2'd0);
            end
        endcase
    endtask

    initial begin
        int n;
        logic [6:0] legal_ops [10];
        legal_ops = '{OP_ITYPE_LOAD, OP_FENCE, OP_ITYPE_LOGIC, OP_UTYPE_AUIPC, OP_STYPE,
                      OP_RTYPE, OP_UTYPE_LUI, OP_BTYPE, OP_ITYPE_JALR, OP_JTYPE};
        reset = 1'b0; opcode = 7'd0; funct3 = 3'd0; mem_ready = 1'b0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        @(posedge clk); #1;
        do_reset(2);
        chk("reset_state", int'(state), 0);
        chk("reset_illegal", int'(illegal_instr), 0);

        // Reset in the middle of an outstanding load request.
        opcode = OP_ITYPE_LOAD; funct3 = 3'd2;
        cyc(S_FETCH, 1'b1, 6'b100110, 2'd0, 2'd2, 2'd2);
        cyc(S_DECODE, 1'b0, 6'b0, 2'd1, 2'd1, 2'd0);
        cyc(S_MEMADR, 1'b0, 6'b0, 2'd2, 2'd1, 2'd0);
        cyc(S_MEMREAD, 1'b0, 6'b101000, 2'd0, 2'd0, 2'd0);
        cyc(S_MEMREAD, 1'b0, 6'b101000, 2'd0, 2'd0, 2'd0);
        do_reset(3);
        chk("midread_reset_state", int'(state), 0);

        // Cycles per instruction with memory answering immediately.
        run_instr(OP_RTYPE, 3'd0, 0, 0, 0, 0, 0, 0, n);       chk("cpi_rtype", n, 4);
        run_instr(OP_ITYPE_LOGIC, 3'd4, 0, 0, 0, 0, 0, 0, n); chk("cpi_itype", n, 4);
        run_instr(OP_UTYPE_LUI, 3'd0, 0, 0, 0, 0, 0, 0, n);   chk("cpi_lui", n, 4);
        run_instr(OP_UTYPE_AUIPC, 3'd0, 0, 0, 0, 0, 0, 0, n); chk("cpi_auipc", n, 4);
        run_instr(OP_ITYPE_LOAD, 3'd2, 0, 0, 0, 0, 0, 0, n);  chk("cpi_load", n, 5);
        run_instr(OP_STYPE, 3'd2, 0, 0, 0, 0, 0, 0, n);       chk("cpi_store", n, 4);
        run_instr(OP_BTYPE, 3'd0, 1, 0, 0, 0, 0, 0, n);       chk("cpi_branch", n, 3);
        run_instr(OP_JTYPE, 3'd0, 0, 0, 0, 0, 0, 0, n);       chk("cpi_jal", n, 4);
        run_instr(OP_ITYPE_JALR, 3'd0, 0, 0, 0, 0, 0, 0, n);  chk("cpi_jalr", n, 4);
        run_instr(OP_FENCE, 3'd0, 0, 0, 0, 0, 0, 0, n);       chk("cpi_fence", n, 2);
        run_instr(OP_ITYPE_LOAD, 3'd2, 0, 0, 0, 0, 3, 0, n);  chk("cpi_load_wait3", n, 8);
        run_instr(OP_BTYPE, 3'd0, 0, 0, 0, 0, 0, 0, n);
        run_instr(OP_BTYPE, 3'd5, 0, 1, 0, 0, 0, 0, n);

        run_instr(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 10, n);
        chk("trap_state", int'(state), 15);
        chk("trap_illegal", int'(illegal_instr), 1);
        do_reset(2);
        chk("trap_cleared", int'(illegal_instr), 0);

        for (int k = 0; k < 300; k++) begin
            logic [6:0] op;
            int fw, mw;
            if ($urandom_range(0, 39) == 0) begin
                do op = 7'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 9)];
            end
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            run_instr(op, 3'($urandom), rnd(), rnd(), rnd(), fw, mw, $urandom_range(1, 5), n);
            if (!is_legal(op)) do_reset($urandom_range(1, 3));
        end

        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
